lzc_norm_pipe: RTL

//   Pipelined leading-zero/one counter with a built-in normalising left shift. It is the

---
 rtl/lzc_norm_pipe.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/lzc_norm_pipe.sv
// Pipelined leading-zero/one counter with normalising left shift and
// valid/ready handshakes on both sides. Mode and tag travel with the data.
module lzc_norm_pipe #(
  parameter  int unsigned WIDTH  = 32,
  parameter  int unsigned STAGES = 2,
  parameter  int unsigned TAG_W  = 4,
  localparam int unsigned CNT_W  = $clog2(WIDTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [WIDTH-1:0] in_data_i,
  input  logic             in_mode_i,
  input  logic [TAG_W-1:0] in_tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [CNT_W-1:0] out_cnt_o,
  output logic [WIDTH-1:0] out_data_o,
  output logic             out_empty_o,
  output logic [TAG_W-1:0] out_tag_o,
  output logic [15:0]      xfer_cnt_o
);

  localparam int unsigned XFER_W = 16;

  // Leading non-target bit count; WIDTH when the target bit is absent.
  function automatic logic [CNT_W-1:0] lead_cnt(input logic [WIDTH-1:0] d,
                                                input logic             m);
    logic [CNT_W-1:0] c;
    c = CNT_W'(WIDTH);
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (d[i] == m) c = CNT_W'(int'(WIDTH) - 1 - i);
    end
    return c;
  endfunction

  // Operand contains no target bit.
  function automatic logic no_target(input logic [WIDTH-1:0] d,
                                     input logic             m);
    return m ? ~(|d) : (&d);
  endfunction

  // Left shift by c, filling vacated LSBs with ~m; c == WIDTH yields all fill.
  function automatic logic [WIDTH-1:0] norm(input logic [WIDTH-1:0] d,
                                            input logic [CNT_W-1:0] c,
                                            input logic             m);
    logic [2*WIDTH-1:0] ext;
    ext = {d, {WIDTH{~m}}} << c;
    return ext[2*WIDTH-1:WIDTH];
  endfunction

  // Per-stage state
  logic [STAGES-1:0] valid_q;
  logic [STAGES-1:0] ready;
  logic [WIDTH-1:0]  data_q  [STAGES];
  logic [CNT_W-1:0]  cnt_q   [STAGES];
  logic [STAGES-1:0] empty_q;
  logic [TAG_W-1:0]  tag_q   [STAGES];
  logic              mode_q;

  // Per-stage load values
  logic [STAGES-1:0] valid_d;
  logic [WIDTH-1:0]  data_d  [STAGES];
  logic [CNT_W-1:0]  cnt_d   [STAGES];
  logic [STAGES-1:0] empty_d;
  logic [TAG_W-1:0]  tag_d   [STAGES];

  logic [CNT_W-1:0]  in_cnt;
  logic [WIDTH-1:0]  in_norm;
  logic [WIDTH-1:0]  shift_data;

  logic [XFER_W-1:0] xfer_q;

  // Front-end count, plus the two shifter placements (pre-register for a single stage).
  always_comb begin
    in_cnt     = lead_cnt(in_data_i, in_mode_i);
    in_norm    = norm(in_data_i, in_cnt, in_mode_i);
    shift_data = norm(data_q[0], cnt_q[0], mode_q);
  end

  // Stall chain: a stage can load when empty or when its successor can load.
  always_comb begin
    logic r;
    ready = '0;
    r     = out_ready_i;
    for (int k = int'(STAGES) - 1; k >= 0; k--) begin
      r        = ~valid_q[k] | r;
      ready[k] = r;
    end
  end

  // Next-stage payload selection: count first, shift after the first register, then retime.
  always_comb begin
    valid_d    = '0;
    empty_d    = '0;
    valid_d[0] = in_valid_i;
    data_d[0]  = (STAGES == 1) ? in_norm : in_data_i;
    cnt_d[0]   = in_cnt;
    empty_d[0] = no_target(in_data_i, in_mode_i);
    tag_d[0]   = in_tag_i;
    for (int k = 1; k < int'(STAGES); k++) begin
      valid_d[k] = valid_q[k-1];
      data_d[k]  = (k == 1) ? shift_data : data_q[k-1];
      cnt_d[k]   = cnt_q[k-1];
      empty_d[k] = empty_q[k-1];
      tag_d[k]   = tag_q[k-1];
    end
  end

  // Pipeline registers; flush clears every valid bit and drops any same-cycle input.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q <= '0;
      empty_q <= '0;
      mode_q  <= 1'b0;
      for (int k = 0; k < int'(STAGES); k++) begin
        data_q[k] <= '0;
        cnt_q[k]  <= '0;
        tag_q[k]  <= '0;
      end
    end else begin
      for (int k = 0; k < int'(STAGES); k++) begin
        if (flush_i) begin
          valid_q[k] <= 1'b0;
        end else if (ready[k]) begin
          valid_q[k] <= valid_d[k];
        end
        if (ready[k] && valid_d[k]) begin
          data_q[k]  <= data_d[k];
          cnt_q[k]   <= cnt_d[k];
          empty_q[k] <= empty_d[k];
          tag_q[k]   <= tag_d[k];
        end
      end
      if (ready[0] && in_valid_i) begin
        mode_q <= in_mode_i;
      end
    end
  end

  // Output handshake counter; unaffected by flush, wraps naturally.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      xfer_q <= '0;
    end else if (out_valid_o && out_ready_i) begin
      xfer_q <= xfer_q + XFER_W'(1);
    end
  end

  assign in_ready_o  = ready[0];
  assign out_valid_o = valid_q[STAGES-1];
  assign out_cnt_o   = cnt_q[STAGES-1];
  assign out_data_o  = data_q[STAGES-1];
  assign out_empty_o = empty_q[STAGES-1];
  assign out_tag_o   = tag_q[STAGES-1];
  assign xfer_cnt_o  = xfer_q;

endmodule
